// File: rtl/arrival_departure_monitor.sv
// Bay occupancy counter with a timed entry gate (CLOSED/OPEN/CLOSING).
// Optional pending-arrival queue at full: define ARRIVAL_QUEUE_EN.
module arrival_departure_monitor #(
  parameter int CAPACITY    = 8,
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriveSignal,
  input  logic       departSignal,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       gateOpen,
  output logic       closingWarn,
  output logic       error
);

  localparam logic [3:0] CAP  = 4'(CAPACITY);
  localparam logic [3:0] GCYC = 4'(GATE_CYCLES);

  typedef enum logic [1:0] {
    CLOSED,
    OPEN,
    CLOSING
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] timer;
  logic [3:0] timer_nx;
  logic [3:0] count_nx;
  logic       error_nx;
  logic       acc;

`ifdef ARRIVAL_QUEUE_EN
  logic [1:0] pend;
  logic [1:0] pend_nx;
`endif

  always_comb begin
    count_nx = count;
    error_nx = error;
    acc      = 1'b0;
`ifdef ARRIVAL_QUEUE_EN
    pend_nx  = pend;
`endif
    if (arriveSignal && departSignal) begin
      acc = 1'b1;
    end else if (arriveSignal) begin
      if (count < CAP) begin
        count_nx = count + 4'd1;
        acc      = 1'b1;
      end else begin
`ifdef ARRIVAL_QUEUE_EN
        if (pend == 2'd3) error_nx = 1'b1;
        else pend_nx = pend + 2'd1;
`else
        error_nx = 1'b1;
`endif
      end
    end else begin
`ifdef ARRIVAL_QUEUE_EN
      // A queued arrival is admitted only in cycles without a new arrival
      if (pend != 2'd0 && count < CAP) begin
        count_nx = count + 4'd1;
        pend_nx  = pend - 2'd1;
        acc      = 1'b1;
      end
`endif
      if (departSignal) begin
        if (count != 4'd0) begin
          count_nx = count_nx - 4'd1;
          acc      = 1'b1;
        end else begin
          error_nx = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    unique case (state)
      CLOSED: begin
        if (acc) begin
          state_nx = OPEN;
          timer_nx = GCYC;
        end
      end
      OPEN: begin
        if (acc) begin
          timer_nx = GCYC;
        end else if (timer <= 4'd1) begin
          state_nx = CLOSING;
          timer_nx = 4'd0;
        end else begin
          timer_nx = timer - 4'd1;
        end
      end
      CLOSING: begin
        if (acc) begin
          state_nx = OPEN;
          timer_nx = GCYC;
        end else begin
          state_nx = CLOSED;
          timer_nx = 4'd0;
        end
      end
      default: begin
        state_nx = CLOSED;
        timer_nx = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= 4'd0;
      error <= 1'b0;
      timer <= 4'd0;
      state <= CLOSED;
    end else begin
      count <= count_nx;
      error <= error_nx;
      timer <= timer_nx;
      state <= state_nx;
    end
  end

`ifdef ARRIVAL_QUEUE_EN
  always_ff @(posedge clk) begin
    if (!rst) pend <= 2'd0;
    else pend <= pend_nx;
  end
`endif

  assign full        = (count == CAP);
  assign empty       = (count == 4'd0);
  assign gateOpen    = (state == OPEN) || (state == CLOSING);
  assign closingWarn = (state == CLOSING);

endmodule

// File: tb/tb_arrival_departure_monitor.sv
// Bench for arrival_departure_monitor: vector table, corner sequences,
// and random traffic against an occupancy/gate-lifetime model.
module tb_arrival_departure_monitor;

  localparam int CAP = 8;
  localparam int G   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a   = 1'b0;
  logic       d   = 1'b0;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       gateOpen;
  logic       closingWarn;
  logic       error;

  arrival_departure_monitor #(
    .CAPACITY(CAP),
    .GATE_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arriveSignal(a),
    .departSignal(d),
    .count(count),
    .full(full),
    .empty(empty),
    .gateOpen(gateOpen),
    .closingWarn(closingWarn),
    .error(error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model: occupancy, sticky error, queue depth, cycles of gate-open left
  int m_cnt  = 0;
  int m_err  = 0;
  int m_pend = 0;
  int m_open = 0;

  typedef struct {
    logic r, ia, id;
    int   c;
    logic f, e, g, w, er;
  } vec_t;

  vec_t tv[24] = '{
    '{0,0,0, 0,0,1,0,0,0},
    '{1,1,0, 1,0,0,1,0,0},
    '{1,1,0, 2,0,0,1,0,0},
    '{1,1,0, 3,0,0,1,0,0},
    '{1,0,0, 3,0,0,1,0,0},
    '{1,0,0, 3,0,0,1,0,0},
    '{1,0,0, 3,0,0,1,0,0},
    '{1,0,0, 3,0,0,1,1,0},
    '{1,0,0, 3,0,0,0,0,0},
    '{1,0,1, 2,0,0,1,0,0},
    '{0,0,0, 0,0,1,0,0,0},
    '{1,0,1, 0,0,1,0,0,1},
    '{0,0,0, 0,0,1,0,0,0},
    '{1,1,1, 0,0,1,1,0,0},
    '{1,0,0, 0,0,1,1,0,0},
    '{1,0,0, 0,0,1,1,0,0},
    '{1,0,0, 0,0,1,1,0,0},
    '{1,0,0, 0,0,1,1,1,0},
    '{1,1,0, 1,0,0,1,0,0},
    '{1,0,0, 1,0,0,1,0,0},
    '{1,0,0, 1,0,0,1,0,0},
    '{1,0,0, 1,0,0,1,0,0},
    '{1,0,0, 1,0,0,1,1,0},
    '{1,0,0, 1,0,0,0,0,0}
  };

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input logic f,
                         input logic e, input logic g, input logic w,
                         input logic er);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".gateOpen"}, 32'(gateOpen), 32'(g));
    chk({tag, ".closingWarn"}, 32'(closingWarn), 32'(w));
    chk({tag, ".error"}, 32'(error), 32'(er));
  endtask

  task automatic model(input logic r, input logic ia, input logic id);
    int c0;
    bit acc;
    c0  = m_cnt;
    acc = 0;
    if (!r) begin
      m_cnt = 0; m_err = 0; m_pend = 0; m_open = 0;
      return;
    end
    if (ia && id) begin
      acc = 1;
    end else if (ia) begin
      if (c0 < CAP) begin
        m_cnt++; acc = 1;
      end else begin
`ifdef ARRIVAL_QUEUE_EN
        if (m_pend == 3) m_err = 1;
        else m_pend++;
`else
        m_err = 1;
`endif
      end
    end else begin
`ifdef ARRIVAL_QUEUE_EN
      if (m_pend > 0 && c0 < CAP) begin
        m_cnt++; m_pend--; acc = 1;
      end
`endif
      if (id) begin
        if (c0 > 0) begin
          m_cnt--; acc = 1;
        end else begin
          m_err = 1;
        end
      end
    end
    // gate stays open G cycles plus one closing cycle after an event
    if (acc) m_open = G + 1;
    else if (m_open > 0) m_open--;
  endtask

  task automatic step(input logic r, input logic ia, input logic id);
    @(negedge clk);
    rst = r; a = ia; d = id;
    @(posedge clk);
    #1;
    model(r, ia, id);
  endtask

  initial begin
    for (int i = 0; i < 24; i++) begin
      step(tv[i].r, tv[i].ia, tv[i].id);
      chk_all($sformatf("vec%0d", i), tv[i].c, tv[i].f, tv[i].e,
              tv[i].g, tv[i].w, tv[i].er);
    end

    step(0, 0, 0);
    repeat (CAP) step(1, 1, 0);
    chk("fill.count", 32'(count), 32'(CAP));
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.empty", 32'(empty), 32'd0);
    step(1, 1, 1);
    chk_all("both_at_full", CAP, 1, 0, 1, 0, 0);
    step(1, 1, 0);
    chk("over.count", 32'(count), 32'(CAP));
`ifdef ARRIVAL_QUEUE_EN
    chk("over.error", 32'(error), 32'd0);
`else
    chk("over.error", 32'(error), 32'd1);
`endif
    step(1, 0, 1);
    chk("dep_full.count", 32'(count), 32'(CAP - 1));
    chk("dep_full.full", 32'(full), 32'd0);
    step(1, 0, 0);
`ifdef ARRIVAL_QUEUE_EN
    chk("admit.count", 32'(count), 32'(CAP));
`else
    chk("admit.count", 32'(count), 32'(CAP - 1));
`endif

    step(0, 0, 0);
    repeat (5) step(1, 1, 0);
    chk("pre_rst.count", 32'(count), 32'd5);
    chk("pre_rst.gate", 32'(gateOpen), 32'd1);
    step(0, 1, 0);
    chk_all("mid_rst", 0, 0, 1, 0, 0, 0);
    step(1, 0, 0);
    chk_all("post_rst", 0, 0, 1, 0, 0, 0);

    step(0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int pa;
      logic r, ia, id;
      pa = ((i / 150) % 2 == 0) ? 70 : 30;
      r  = ($urandom_range(0, 199) != 0);
      ia = ($urandom_range(0, 99) < pa);
      id = ($urandom_range(0, 99) < (100 - pa));
      if ($urandom_range(0, 3) == 0) begin
        ia = 1'b0;
        id = 1'b0;
      end
      step(r, ia, id);
      chk_all($sformatf("rnd%0d", i), m_cnt, logic'(m_cnt == CAP),
              logic'(m_cnt == 0), logic'(m_open > 0), logic'(m_open == 1),
              logic'(m_err != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
